// File: rtl/regs_req_master_pkg.sv
// rtl/regs_req_master_pkg.sv - shared constants and FSM encoding for regs_req_master
// Purpose: default bus widths, rw encoding and the request FSM state type,
//          imported by the interface, the command FIFO user and the top.
// Ports:   none (package).
package regs_req_master_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;

endpackage

// File: rtl/regs_req_master_if.sv
// rtl/regs_req_master_if.sv - host command/response and register bank signal bundle
// Purpose: groups the host-side command/response handshake and the four-phase
//          register bank request/acknowledge signals.
// Ports:   host_valid/host_ready/host_rw/host_addr/host_wdata  host command in
//          resp_valid/resp_rdata/resp_err                       host response out
//          req/rw/addr/data_in                                  bank request out
//          ack/data_out                                         bank acknowledge in
//          modport master: the request master's view; modport slave: host + bank view.
interface regs_req_master_if
  import regs_req_master_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  host_valid;
  logic                  host_ready;
  logic                  host_rw;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic                  req;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;

  logic                  ack;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  host_valid, host_rw, host_addr, host_wdata, ack, data_out,
    output host_ready, resp_valid, resp_rdata, resp_err, req, rw, addr, data_in
  );

  modport slave (
    output host_valid, host_rw, host_addr, host_wdata, ack, data_out,
    input  host_ready, resp_valid, resp_rdata, resp_err, req, rw, addr, data_in
  );

endinterface

// File: rtl/regs_cmd_fifo.sv
// rtl/regs_cmd_fifo.sv - in-order command queue for regs_req_master
// Purpose: DEPTH-entry FIFO (DEPTH a power of two) with occupancy count.
// Ports:   clk, reset        clock, synchronous active-high reset
//          push_i, wdata_i   write an entry (ignored when full)
//          pop_i, rdata_o    drop the head entry (ignored when empty); rdata_o shows head
//          full_o, empty_o   flags derived from the occupancy count
//          count_o           occupancy 0..DEPTH
module regs_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) bits wide, so natural overflow is the
  // modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/regs_req_master.sv
// rtl/regs_req_master.sv - queued four-phase register bank request master
// Purpose: accepts host read/write commands into a FIFO and replays them one
//          at a time on a req/ack four-phase handshake, with a per-command
//          ack timeout and a one-cycle completion pulse per command.
// Ports:   clk    sole clock, rising edge
//          reset  synchronous active-high reset
//          bus    regs_req_master_if.master (host command/response + bank req/ack)
module regs_req_master
  import regs_req_master_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic               clk,
  input logic               reset,
  regs_req_master_if.master bus
);

  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;

  logic [CMD_W-1:0]      push_cmd;
  logic [CMD_W-1:0]      head_cmd;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic                  timed_out;

  logic                  req_q, req_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TCW-1:0]        cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  assign push     = bus.host_valid && !fifo_full;
  assign push_cmd = {bus.host_rw, bus.host_addr, bus.host_wdata};

  regs_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Flags and occupancy come from one counter and must never disagree.
  always_ff @(posedge clk) begin
    if (!reset) assert (fifo_empty == (fifo_count == '0));
  end

  // cnt_q counts completed WAIT_ACK cycles, so the TIMEOUT-th cycle without
  // ack is the one where it still reads TIMEOUT-1.
  assign timed_out = !bus.ack && (cnt_q == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!fifo_empty) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (bus.ack || timed_out) state_d = RELEASE;
      RELEASE:  if (!bus.ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    req_d        = req_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop                    = 1'b1;
          {rw_d, addr_d, data_d} = head_cmd;
        end
      end
      ISSUE: begin
        req_d = 1'b1;
        cnt_d = '0;
      end
      WAIT_ACK: begin
        if (bus.ack) begin
          req_d        = 1'b0;
          resp_valid_d = 1'b1;
          if (rw_q == RW_READ) resp_rdata_d = bus.data_out;
        end else if (timed_out) begin
          req_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
        if (cnt_q != TCW'(TIMEOUT)) cnt_d = cnt_q + TCW'(1);
      end
      default: ;
    endcase
  end

  // rw/addr/data_in only reload in IDLE, so they hold through req and the
  // whole RELEASE phase until ack is back low.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= 1'b0;
      rw_q         <= RW_WRITE;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      req_q        <= req_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.host_ready = !fifo_full;
  assign bus.req        = req_q;
  assign bus.rw         = rw_q;
  assign bus.addr       = addr_q;
  assign bus.data_in    = data_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_regs_req_master.sv
// tb/tb_regs_req_master.sv - self-checking bench for regs_req_master
// Purpose: table of single-command vectors plus hand sequences for queue
//          full, ack held after release and reset mid-transaction.
// Ports:   none (top-level bench).
module tb_regs_req_master;
  import regs_req_master_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regs_req_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regs_req_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    bit            never;
    int            hold;
    logic [DW-1:0] bank_rdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_reqc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.host_valid = 1'b1;
    bus.host_rw    = rw;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
  endtask

  task automatic wait_req(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.req) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int            rise_at  = -1;
    int            reqc     = 0;
    int            pulses   = 0;
    int            hold_cnt = 0;
    logic [DW-1:0] rd       = '0;
    logic          er       = 1'b0;
    bit            stable   = 1'b1;
    drive_cmd(v.rw, v.addr, v.wdata);
    tick();
    bus.host_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (bus.req) begin
        reqc++;
        if (rise_at < 0) rise_at = cyc;
      end
      if ((bus.req || bus.ack) &&
          (bus.rw !== v.rw || bus.addr !== v.addr || bus.data_in !== v.wdata)) stable = 1'b0;
      if (bus.resp_valid) begin
        pulses++;
        rd = bus.resp_rdata;
        er = bus.resp_err;
      end
      if (bus.req && !v.never && (cyc - rise_at + 1) >= v.delay) begin
        bus.ack      = 1'b1;
        bus.data_out = v.bank_rdata;
      end else if (!bus.req && bus.ack) begin
        if (hold_cnt == v.hold) bus.ack = 1'b0;
        else hold_cnt++;
      end
    end
    check($sformatf("v%0d_req_latency", idx), 64'(rise_at), 64'd2);
    check($sformatf("v%0d_req_cycles", idx), 64'(reqc), 64'(v.exp_reqc));
    check($sformatf("v%0d_stable", idx), 64'(stable), 64'd1);
    check($sformatf("v%0d_resp_pulses", idx), 64'(pulses), 64'd1);
    check($sformatf("v%0d_resp_rdata", idx), 64'(rd), 64'(v.exp_rdata));
    check($sformatf("v%0d_resp_err", idx), 64'(er), 64'(v.exp_err));
  endtask

  initial begin
    int            lat;
    int            waited;
    bit            flag;
    bit            ready_low;
    int            pulses;
    logic [AW-1:0] seen[$];

    vecs[0] = '{RW_WRITE, 5'b00000, 32'h00000001, 2, 1'b0, 0, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
    vecs[1] = '{RW_READ,  5'b00100, 32'h00000000, 1, 1'b0, 0, 32'h01010001, 32'h01010001, 1'b0, 1};
    vecs[2] = '{RW_READ,  5'b10110, 32'h00000000, 0, 1'b1, 0, 32'h00000000, 32'h00000000, 1'b1, TO};
    vecs[3] = '{RW_READ,  5'b11111, 32'hCAFE0000, 5, 1'b0, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5};
    vecs[4] = '{RW_WRITE, 5'b01010, 32'hA5A5A5A5, 3, 1'b0, 1, 32'h12345678, 32'h00000000, 1'b0, 3};

    bus.host_valid = 1'b0;
    bus.host_rw    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.ack        = 1'b0;
    bus.data_out   = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_req", 64'(bus.req), 64'd0);
    check("rst_rw", 64'(bus.rw), 64'd0);
    check("rst_addr", 64'(bus.addr), 64'd0);
    check("rst_data_in", 64'(bus.data_in), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_host_ready", 64'(bus.host_ready), 64'd1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Ack held high 3 cycles after req drop; queued command must wait for ack low.
    drive_cmd(RW_WRITE, 5'd3, 32'h33);
    tick();
    drive_cmd(RW_WRITE, 5'd9, 32'h99);
    tick();
    bus.host_valid = 1'b0;
    wait_req(lat);
    check("hold_first_req_seen", 64'(lat > 0), 64'd1);
    bus.ack = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.req) flag = 1'b1;
    end
    check("hold_no_req_while_ack", 64'(flag), 64'd0);
    bus.ack = 1'b0;
    wait_req(lat);
    check("hold_next_req_latency", 64'(lat), 64'd3);
    check("hold_next_req_addr", 64'(bus.addr), 64'd9);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    repeat (3) tick();

    // Queue fill: one command in flight, then 5 pushed back-to-back.
    drive_cmd(RW_WRITE, 5'd1, 32'h1);
    tick();
    bus.host_valid = 1'b0;
    wait_req(lat);
    check("fill_inflight_req", 64'(lat), 64'd2);
    for (int i = 0; i < 4; i++) begin
      drive_cmd(RW_WRITE, AW'(10 + i), DW'(i));
      check($sformatf("fill_ready_%0d", i), 64'(bus.host_ready), 64'd1);
      tick();
    end
    drive_cmd(RW_WRITE, 5'd14, 32'h4);
    check("fill_ready_low_after_4", 64'(bus.host_ready), 64'd0);
    ready_low = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.host_ready) ready_low = 1'b0;
    end
    check("fill_fifth_held", 64'(ready_low), 64'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    waited = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.host_ready) begin
        waited = k;
        break;
      end
    end
    check("fill_ready_after_pop", 64'(waited), 64'd2);
    tick();
    bus.host_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      if (bus.resp_valid) pulses++;
      if (bus.req && !bus.ack) begin
        seen.push_back(bus.addr);
        bus.ack = 1'b1;
      end else if (!bus.req && bus.ack) begin
        bus.ack = 1'b0;
      end
      tick();
    end
    check("fill_served_count", 64'(seen.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen.size()) check($sformatf("fill_order_%0d", i), 64'(seen[i]), 64'(10 + i));
      else check($sformatf("fill_order_%0d", i), 64'hFFFF, 64'(10 + i));
    end
    check("fill_resp_pulses", 64'(pulses), 64'd5);

    // Reset while in WAIT_ACK with two commands queued.
    drive_cmd(RW_READ, 5'd2, 32'h0);
    tick();
    bus.host_valid = 1'b0;
    wait_req(lat);
    check("rstmid_req_seen", 64'(lat), 64'd2);
    drive_cmd(RW_WRITE, 5'd6, 32'h6);
    tick();
    drive_cmd(RW_WRITE, 5'd7, 32'h7);
    tick();
    bus.host_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("rstmid_req_dropped", 64'(bus.req), 64'd0);
    check("rstmid_host_ready", 64'(bus.host_ready), 64'd1);
    check("rstmid_no_resp", 64'(bus.resp_valid), 64'd0);
    reset = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.req || bus.resp_valid) flag = 1'b1;
    end
    check("rstmid_queue_empty", 64'(flag), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1);
  end

endmodule
